lfsr_voice_bank: RTL and testbench
==================================

Name: lfsr_voice_bank

Overview:
Parametrised bank of NUM_CH LFSR noise voices for the FPGA piano. Each raw key/switch input is synchronised and debounced per channel, then gates its voice enable in one of two modes (gated or toggle). Enabled voices step a WIDTH-bit Fibonacci LFSR on a shared step strobe, and a registered mixer sums all enabled voices for the audio path. It replaces the fixed three-switch conditioner, LUT and three 8-bit LFSR arrangement.

Parameters:
NUM_CH, 8, number of key/voice channels (1..16)
WIDTH, 8, LFSR width in bits (4..16)
TAPS, 8'hB8, feedback tap mask over state bits; bit i set means state[i] feeds the XOR
SEED_BASE, 1, seed of channel i is SEED_BASE+i (mod 2^WIDTH); a result of 0 is replaced by 1
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a key change (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_raw  in  NUM_CH  raw asynchronous key/switch levels
mode  in  1  0 = gated (voice on while key held), 1 = toggle (each press flips the voice)
step_en  in  1  shared LFSR advance strobe, synchronous to clk
key_cond  out  NUM_CH  debounced key levels
key_press  out  NUM_CH  one-cycle pulse when key_cond rises
ch_en  out  NUM_CH  voice enable per channel
lfsr_out  out  NUM_CH*WIDTH  channel i state at [i*WIDTH +: WIDTH]
mix_out  out  WIDTH+$clog2(NUM_CH+1)  registered sum of enabled channel states
active_count  out  $clog2(NUM_CH+1)  registered number of enabled channels

Behaviour:
- Reset (async, rst_n=0):
  - sync flops, key_cond, debounce counters, key_press, ch_en, mix_out and active_count all return to 0.
  - Each LFSR loads its channel seed.
  - Effect is immediate, including mid-operation.
- Conditioner, per channel:
  - Two-flop synchroniser s1->s2.
  - Counter cnt clears while s2==key_cond; increments while s2!=key_cond.
  - When s2!=key_cond and cnt==DEBOUNCE_CYCLES-1: key_cond<=s2 and cnt<=0.
  - A single cycle of s2==key_cond restarts the count.
  - Latency: key_cond follows a clean input edge on the (DEBOUNCE_CYCLES+2)th rising edge after the edge that first samples it.
  - key_press is registered: high for exactly the cycle after key_cond goes 0->1.
- Enable:
  - mode=0: ch_en tracks key_cond, same cycle as key_cond.
  - mode=1: ch_en flips on each key_press cycle; key release has no effect.
  - A mode change takes effect next cycle. On a 1->0 change, ch_en immediately equals key_cond.
- LFSR, per channel:
  - Rising edge of ch_en (registered previous value 0, now 1): state<=seed. Seed load wins over stepping that cycle.
  - Else if ch_en && step_en: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
  - Else hold. A disabled channel holds its last state.
  - Lockup guard: if state==0, reload the seed next cycle, regardless of step_en.
  - With defaults the sequence from 8'h01 is 01,02,04,08,11,... and the period is 255.
- Mixer:
  - mix_out <= sum over i of (ch_en[i] ? state_i : 0), computed from the current-cycle registered states.
  - active_count <= popcount(ch_en).
  - Latency 1 cycle. No overflow: the width covers NUM_CH*(2^WIDTH-1).

Decomposition:
- Shared package lfsr_bank_pkg: mode encodings MODE_GATED=0 and MODE_TOGGLE=1, default tap masks per width (4:4'h9, 8:8'hB8, 16:16'hB400), and a seed-function helper.
- One natural sub-module, lfsr_key_conditioner (sync + debounce + press pulse), instantiated NUM_CH times in a generate loop.
- LFSR and mixer stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with keys toggling -> all outputs 0; lfsr_out channel0=8'h01, channel1=8'h02, channel7=8'h08.
- Debounce, DEBOUNCE_CYCLES=4: key_raw[0] rises cleanly -> key_cond[0] high on edge 6 and key_press[0] high for 1 cycle after. A 3-cycle glitch pulse -> no change on key_cond.
- Gated stepping, mode=0, step_en=1, key0 held: channel0 produces 01,02,04,08,11 on successive cycles. mix_out lags by 1 cycle; active_count=1. On release, ch_en=0, the state holds and mix_out returns to 0.
- Toggle mode, mode=1: press/release key2 -> ch_en[2]=1 stays high after release. A second press -> ch_en[2]=0. The LFSR reloads 8'h03 on the re-enable edge.
- step_en gating: key held, step_en low for 10 cycles -> state frozen. Assert step_en -> resumes from the frozen value.
- Reset mid-run: assert rst_n low asynchronously between clock edges during stepping -> outputs clear without waiting for a clock edge; states reseed. Release -> no key_press until a new debounced press.

Source files
------------

// File: rtl/lfsr_bank_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_bank_pkg
//   Shared definitions for the LFSR voice bank:
//     - mode_e        : voice enable mode (gated / toggle)
//     - TAPS_Wn       : maximal-length Fibonacci tap masks for common widths
//     - default_taps  : tap mask lookup by width
//     - seed_of       : per-channel seed (base + index, wrapped, never zero)
// ---------------------------------------------------------------------------
package lfsr_bank_pkg;

    typedef enum logic {
        MODE_GATED  = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;

    localparam logic [3:0]  TAPS_W4  = 4'h9;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    // Widths without a tabulated mask fall back to the top two bits; such
    // a mask is not guaranteed maximal-length, so callers using an odd width
    // should pass TAPS explicitly.
    function automatic logic [15:0] default_taps(input int unsigned width);
        logic [15:0] t;
        case (width)
            4:       t = 16'(TAPS_W4);
            8:       t = 16'(TAPS_W8);
            16:      t = TAPS_W16;
            default: t = (16'd1 << (width - 1)) | (16'd1 << (width - 2));
        endcase
        return t;
    endfunction

    // Seed for channel idx: (base + idx) mod 2^width, with 0 mapped to 1 so
    // that no voice ever starts in the all-zero lockup state.
    function automatic logic [15:0] seed_of(input int unsigned base,
                                            input int unsigned idx,
                                            input int unsigned width);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (32'd1 << width) - 32'd1;
        s    = (base + idx) & mask;
        if (s == 32'd0) begin
            s = 32'd1;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/lfsr_key_conditioner.sv
// ---------------------------------------------------------------------------
// lfsr_key_conditioner
//   One key channel: two-flop synchroniser, counter debounce and a registered
//   press pulse.
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     key_raw    in   raw asynchronous key level
//     key_cond   out  debounced key level
//     key_press  out  one-cycle pulse, the cycle after key_cond rises
// ---------------------------------------------------------------------------
module lfsr_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_cond,
    output logic key_press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             cond_q, cond_d;
    logic             cond_prev_q, cond_prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d        = key_raw;
        s2_d        = s1_q;
        cond_d      = cond_q;
        cnt_d       = '0;
        cond_prev_d = cond_q;
        // Pulse lands the cycle after the debounced level rose.
        press_d     = cond_q & ~cond_prev_q;
        // Any single cycle of agreement leaves cnt_d at zero, restarting
        // the stability window.
        if (s2_q != cond_q) begin
            if (cnt_q == CNT_LAST) begin
                cond_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cond_q      <= 1'b0;
            cond_prev_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cond_q      <= cond_d;
            cond_prev_q <= cond_prev_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign key_cond  = cond_q;
    assign key_press = press_q;

endmodule

// File: rtl/lfsr_voice_bank.sv
// ---------------------------------------------------------------------------
// lfsr_voice_bank
//   NUM_CH LFSR noise voices. Each key is conditioned, gates its voice in
//   gated or toggle mode, enabled voices step a Fibonacci LFSR on step_en,
//   and a registered mixer sums the enabled voices.
//   Ports:
//     clk           in   system clock
//     rst_n         in   asynchronous active-low reset
//     key_raw       in   [NUM_CH]        raw key levels
//     mode          in   0 gated, 1 toggle
//     step_en       in   shared LFSR advance strobe
//     key_cond      out  [NUM_CH]        debounced key levels
//     key_press     out  [NUM_CH]        press pulses
//     ch_en         out  [NUM_CH]        voice enables
//     lfsr_out      out  [NUM_CH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//     mix_out       out  registered sum of enabled voice states
//     active_count  out  registered number of enabled voices
// ---------------------------------------------------------------------------
module lfsr_voice_bank
    import lfsr_bank_pkg::*;
#(
    parameter int               NUM_CH          = 8,
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] TAPS            = WIDTH'(default_taps(WIDTH)),
    parameter int               SEED_BASE       = 1,
    parameter int               DEBOUNCE_CYCLES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     key_raw,
    input  logic                                  mode,
    input  logic                                  step_en,
    output logic [NUM_CH-1:0]                     key_cond,
    output logic [NUM_CH-1:0]                     key_press,
    output logic [NUM_CH-1:0]                     ch_en,
    output logic [NUM_CH*WIDTH-1:0]               lfsr_out,
    output logic [WIDTH+$clog2(NUM_CH+1)-1:0]     mix_out,
    output logic [$clog2(NUM_CH+1)-1:0]           active_count
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int MIX_W = WIDTH + CNT_W;

    function automatic logic [NUM_CH-1:0][WIDTH-1:0] seed_table();
        logic [NUM_CH-1:0][WIDTH-1:0] t;
        for (int i = 0; i < NUM_CH; i++) begin
            t[i] = WIDTH'(seed_of(unsigned'(SEED_BASE), unsigned'(i),
                                  unsigned'(WIDTH)));
        end
        return t;
    endfunction

    localparam logic [NUM_CH-1:0][WIDTH-1:0] SEEDS = seed_table();

    // ---------------------------------------------------------------
    // Key conditioners
    // ---------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_key
        lfsr_key_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_raw  (key_raw[g]),
            .key_cond (key_cond[g]),
            .key_press(key_press[g])
        );
    end

    // ---------------------------------------------------------------
    // Voice enable
    // ---------------------------------------------------------------
    mode_e                         mode_q, mode_d;
    logic [NUM_CH-1:0]             tog_q, tog_d;
    logic [NUM_CH-1:0]             en_prev_q, en_prev_d;

    // tog_q always shadows the live enable with any press applied, so a
    // switch into toggle mode continues from the voice's current state.
    assign ch_en = (mode_q == MODE_TOGGLE) ? tog_q : key_cond;

    always_comb begin
        mode_d    = mode_e'(mode);
        tog_d     = ch_en ^ key_press;
        en_prev_d = ch_en;
    end

    // ---------------------------------------------------------------
    // LFSR voices
    // ---------------------------------------------------------------
    logic [NUM_CH-1:0][WIDTH-1:0]  state_q, state_d;

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_en[i] && !en_prev_q[i]) begin
                // A fresh enable restarts the voice from its seed.
                state_d[i] = SEEDS[i];
            end else if (state_q[i] == '0) begin
                // Lockup guard: the all-zero state is a fixed point.
                state_d[i] = SEEDS[i];
            end else if (ch_en[i] && step_en) begin
                state_d[i] = {state_q[i][WIDTH-2:0], ^(state_q[i] & TAPS)};
            end
        end
    end

    // ---------------------------------------------------------------
    // Mixer
    // ---------------------------------------------------------------
    logic [MIX_W-1:0]              mix_q, mix_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    always_comb begin
        mix_d = '0;
        cnt_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_en[i]) begin
                mix_d = mix_d + MIX_W'(state_q[i]);
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_GATED;
            tog_q     <= '0;
            en_prev_q <= '0;
            state_q   <= SEEDS;
            mix_q     <= '0;
            cnt_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            tog_q     <= tog_d;
            en_prev_q <= en_prev_d;
            state_q   <= state_d;
            mix_q     <= mix_d;
            cnt_q     <= cnt_d;
        end
    end

    assign lfsr_out     = state_q;
    assign mix_out      = mix_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_lfsr_voice_bank.sv
// Bench for lfsr_voice_bank with default parameters (8 voices, 8-bit LFSR,
// taps B8, seeds 1..8, 4-cycle debounce).
module tb_lfsr_voice_bank;

    localparam int NCH = 8;
    localparam int DB  = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  key_raw;
    logic        mode;
    logic        step_en;
    logic [7:0]  key_cond;
    logic [7:0]  key_press;
    logic [7:0]  ch_en;
    logic [63:0] lfsr_out;
    logic [11:0] mix_out;
    logic [3:0]  active_count;

    lfsr_voice_bank dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .mode        (mode),
        .step_en     (step_en),
        .key_cond    (key_cond),
        .key_press   (key_press),
        .ch_en       (ch_en),
        .lfsr_out    (lfsr_out),
        .mix_out     (mix_out),
        .active_count(active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: raw sample history per key, debounced level,
    // press flag, enable, LFSR value as plain integers.
    // ------------------------------------------------------------------
    bit [31:0] m_hist [NCH];
    bit        m_cond [NCH];
    bit        m_rose [NCH];
    bit        m_press[NCH];
    bit        m_en   [NCH];
    bit        m_enp  [NCH];
    int        m_st   [NCH];
    int        m_mix;
    int        m_cnt;

    function automatic int seed(int i);
        int s;
        s = (1 + i) % 256;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int lfsr_next(int s);
        return ((s * 2) % 256) + ($countones(s & 'hB8) % 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_hist[i] = 0; m_cond[i] = 0; m_rose[i] = 0; m_press[i] = 0;
            m_en[i] = 0; m_enp[i] = 0; m_st[i] = seed(i);
        end
        m_mix = 0;
        m_cnt = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_mix = 0;
            m_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                if (m_en[i]) begin
                    m_mix += m_st[i];
                    m_cnt++;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                bit all_diff;
                bit nc;
                all_diff = 1'b1;
                // Synchronised level seen over the last DB cycles is
                // raw sampled 2..DB+1 edges ago.
                for (int j = 1; j <= DB; j++) begin
                    if (m_hist[i][j] == m_cond[i]) all_diff = 1'b0;
                end
                nc = all_diff ? !m_cond[i] : m_cond[i];
                if (m_en[i] && !m_enp[i])        m_st[i] = seed(i);
                else if (m_st[i] == 0)           m_st[i] = seed(i);
                else if (m_en[i] && step_en)     m_st[i] = lfsr_next(m_st[i]);
                m_enp[i]   = m_en[i];
                m_en[i]    = mode ? (m_en[i] ^ m_press[i]) : nc;
                m_press[i] = m_rose[i];
                m_rose[i]  = nc && !m_cond[i];
                m_cond[i]  = nc;
                m_hist[i]  = {m_hist[i][30:0], key_raw[i]};
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            logic [7:0]  e_cond, e_press, e_en;
            logic [63:0] e_lfsr;
            for (int i = 0; i < NCH; i++) begin
                e_cond[i]          = m_cond[i];
                e_press[i]         = m_press[i];
                e_en[i]            = m_en[i];
                e_lfsr[i*8 +: 8]   = 8'(m_st[i]);
            end
            chk("m_key_cond", key_cond, e_cond);
            chk("m_key_press", key_press, e_press);
            chk("m_ch_en", ch_en, e_en);
            chk("m_lfsr_out", lfsr_out, e_lfsr);
            chk("m_mix_out", mix_out, 64'(m_mix));
            chk("m_active_count", active_count, 64'(m_cnt));
        end
    end

    task automatic rand_cycles(int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 11) == 0) key_raw[i] = ~key_raw[i];
            end
            if ($urandom_range(0, 79) == 0) mode = ~mode;
            step_en = ($urandom_range(0, 3) != 0);
        end
    endtask

    int  seqv[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    bit  found;

    initial begin
        rst_n   = 1'b0;
        key_raw = '0;
        mode    = 1'b0;
        step_en = 1'b0;
        model_reset();

        // Reset with keys toggling.
        repeat (4) begin
            @(posedge clk);
            #2 key_raw = 8'($urandom);
        end
        run_cmp = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_key_cond", key_cond, 0);
        chk("rst_key_press", key_press, 0);
        chk("rst_ch_en", ch_en, 0);
        chk("rst_mix", mix_out, 0);
        chk("rst_count", active_count, 0);
        chk("rst_lfsr_ch0", lfsr_out[7:0], 8'h01);
        chk("rst_lfsr_ch1", lfsr_out[15:8], 8'h02);
        chk("rst_lfsr_ch7", lfsr_out[63:56], 8'h08);
        #1;
        key_raw = '0;
        rst_n   = 1'b1;
        repeat (5) @(posedge clk);
        #2;

        // Clean press on key0: key_cond on edge 6, press on edge 7.
        key_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk("deb_cond", key_cond[0], (k >= 6) ? 1 : 0);
            chk("deb_press", key_press[0], (k == 7) ? 1 : 0);
        end
        chk("gate_seed", lfsr_out[7:0], 8'h01);
        chk("gate_mix0", mix_out, 1);
        chk("gate_cnt0", active_count, 1);
        #1 step_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("gate_seq", lfsr_out[7:0], 64'(seqv[k+1]));
            chk("gate_mix_lag", mix_out, 64'(seqv[k]));
            chk("gate_cnt", active_count, 1);
        end
        #1 key_raw[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rel_ch_en", ch_en[0], 0);
        chk("rel_mix", mix_out, 0);
        chk("rel_cnt", active_count, 0);

        // 3-cycle glitch on key1 must be rejected.
        #1 key_raw[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2 key_raw[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 chk("glitch_cond", key_cond[1], 0);
        end

        // Toggle mode on key2.
        #1 mode = 1'b1;
        key_raw[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1 if (ch_en[2]) found = 1'b1;
        end
        chk("tog_on_wait", found, 1);
        @(posedge clk);
        #1 chk("tog_seed1", lfsr_out[23:16], 8'h03);
        #1 key_raw[2] = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("tog_hold", ch_en[2], 1);
        #1 key_raw[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("tog_off", ch_en[2], 0);
        #1 key_raw[2] = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("tog_off_rel", ch_en[2], 0);
        #1 key_raw[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1 if (ch_en[2]) found = 1'b1;
        end
        chk("tog_re_wait", found, 1);
        @(posedge clk);
        #1 chk("tog_reseed", lfsr_out[23:16], 8'h03);
        #1 key_raw[2] = 1'b0;
        repeat (10) @(posedge clk);
        #2 mode = 1'b0;

        // step_en gating on key3.
        step_en    = 1'b0;
        key_raw[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("stp_en", ch_en[3], 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 chk("stp_frozen", lfsr_out[31:24], 8'h04);
        end
        #1 step_en = 1'b1;
        @(posedge clk);
        #1 chk("stp_resume1", lfsr_out[31:24], 8'h08);
        @(posedge clk);
        #1 chk("stp_resume2", lfsr_out[31:24], 8'h11);
        #1 key_raw[3] = 1'b0;

        rand_cycles(700);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        key_raw = 8'hFF;
        #1;
        chk("arst_cond", key_cond, 0);
        chk("arst_press", key_press, 0);
        chk("arst_en", ch_en, 0);
        chk("arst_mix", mix_out, 0);
        chk("arst_cnt", active_count, 0);
        chk("arst_lfsr", lfsr_out, 64'h0807060504030201);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mode  = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1 chk("arst_nopress", key_press, (k == 7) ? 8'hFF : 8'h00);
        end
        #1;

        rand_cycles(800);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
